// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM row fetch engine.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // RAM issue-to-FIFO-capture latency in clocks
    localparam int unsigned FETCH_LAT = 2;
    localparam int unsigned COL_W     = 8;

endpackage

// File: rtl/vram_fetch_fifo.sv
// Small register-array FIFO holding fetched bytes; the head is visible before it is popped.
module fetch_fifo
    import vram_pkg::*;
#(
    parameter int unsigned D     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic [D-1:0]                 i_din,
    input  logic                         i_pop,
    output logic [D-1:0]                 o_dout,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH):0]       o_occ
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH) + 1;

    logic [D-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [OW-1:0] r_occ;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_occ == '0);
    assign o_full  = (r_occ == OW'(DEPTH));
    assign o_occ   = r_occ;
    assign o_dout  = r_mem[r_rd];

    // A push while full is only accepted when the head leaves on the same edge
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(i_push && o_full && !i_pop));
        end
    end

endmodule

// File: rtl/vram_fetch.sv
// Row fetch DMA: issues RAM reads under credit control and streams bytes to a valid/ready consumer.
module vram_fetch
    import vram_pkg::*;
#(
    parameter int unsigned A     = 10,
    parameter int unsigned D     = 8,
    parameter int unsigned COLS  = 32,
    parameter int unsigned R     = 5,
    parameter int unsigned BASE  = 0,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [R-1:0] i_row,
    output logic         o_ram_cs,
    output logic         o_ram_rw,
    output logic [A-1:0] o_ram_addr,
    input  logic [D-1:0] i_ram_dout,
    output logic [D-1:0] o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned PW = A + R + COL_W;
    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = OW + 1;
    localparam int unsigned LW = $clog2(FETCH_LAT + 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [A-1:0]     r_base;
    logic [A-1:0]     r_addr;
    logic             r_cs;
    logic             r_rd_vld;
    logic [LW-1:0]    r_out;
    logic             r_busy;
    logic             r_done;

    logic [OW-1:0]    w_occ;
    logic             w_empty;
    logic             w_full;
    logic [D-1:0]     w_fifo_dout;
    logic             w_push;
    logic             w_pop;
    logic             w_credit;
    logic [A-1:0]     w_row_base;
    logic             w_start_ok;
    logic             w_issue_fetch;
    logic             w_issue;
    logic             w_last_col;
    logic             w_finish;

    fetch_fifo #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_din   (i_ram_dout),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_occ   (w_occ)
    );

    assign o_ram_cs    = r_cs;
    assign o_ram_rw    = 1'b0;
    assign o_ram_addr  = r_addr;
    assign o_out_data  = w_fifo_dout;
    assign o_out_valid = !w_empty;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    assign w_push     = r_rd_vld;
    assign w_pop      = !w_empty && i_out_ready;
    // A read may be issued only if its byte is guaranteed a FIFO slot on arrival
    assign w_credit   = (CW'(w_occ) + CW'(r_out)) < CW'(DEPTH);
    assign w_row_base = A'(PW'(BASE) + PW'(i_row) * PW'(COLS));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = (COLS == 1) ? DRAIN : FETCH;
            FETCH:   if (w_issue_fetch && w_last_col) w_state_nxt = DRAIN;
            DRAIN:   if (w_finish) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The last byte leaves when nothing remains in flight and the FIFO holds one entry
    always_comb begin
        w_start_ok    = 1'b0;
        w_issue_fetch = 1'b0;
        w_finish      = 1'b0;
        w_last_col    = (r_col == COL_W'(COLS - 1));
        case (r_state)
            IDLE:    w_start_ok    = i_start;
            FETCH:   w_issue_fetch = w_credit;
            DRAIN:   w_finish      = w_pop && (w_occ == OW'(1)) && (r_out == '0);
            default: ;
        endcase
        w_issue = w_start_ok || w_issue_fetch;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col    <= '0;
            r_base   <= '0;
            r_addr   <= '0;
            r_cs     <= 1'b0;
            r_rd_vld <= 1'b0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cs     <= w_issue;
            r_rd_vld <= r_cs;
            r_done   <= w_finish;
            if (w_start_ok) begin
                r_base <= w_row_base;
                r_addr <= w_row_base;
                r_col  <= COL_W'(1);
                r_busy <= 1'b1;
            end else if (w_issue_fetch) begin
                r_addr <= r_base + A'(r_col);
                r_col  <= r_col + COL_W'(1);
            end
            if (w_finish) begin
                r_busy <= 1'b0;
            end
            case ({w_issue, w_push})
                2'b10:   r_out <= r_out + LW'(1);
                2'b01:   r_out <= r_out - LW'(1);
                default: r_out <= r_out;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fetch.sv
// Directed self-checking bench for vram_fetch with a behavioural synchronous-read RAM.
module tb_vram_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start_b;
    logic [4:0] row, row_b;
    logic       ram_cs, ram_cs_b;
    logic       ram_rw, ram_rw_b;
    logic [9:0] ram_addr, ram_addr_b;
    logic [7:0] ram_dout, ram_dout_b;
    logic [7:0] out_data, out_data_b;
    logic       out_valid, out_valid_b;
    logic       out_ready, out_ready_b;
    logic       busy, busy_b;
    logic       done, done_b;

    logic [7:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    int n_issue, n_xfer, n_xfer_old, n_done, credit_viol, stall_viol;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] got_q[$];
    logic [7:0] got_q_b[$];
    logic [9:0] addr_q_b[$];

    always #5 clk = ~clk;

    vram_fetch u_dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_row(row),
        .o_ram_cs(ram_cs), .o_ram_rw(ram_rw), .o_ram_addr(ram_addr), .i_ram_dout(ram_dout),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_busy(busy), .o_done(done)
    );

    vram_fetch #(.BASE(32'h3F0)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_row(row_b),
        .o_ram_cs(ram_cs_b), .o_ram_rw(ram_rw_b), .o_ram_addr(ram_addr_b), .i_ram_dout(ram_dout_b),
        .o_out_data(out_data_b), .o_out_valid(out_valid_b), .i_out_ready(out_ready_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    always @(posedge clk) begin
        if (ram_cs && !ram_rw) ram_dout <= mem[ram_addr];
        if (ram_cs_b && !ram_rw_b) ram_dout_b <= mem[ram_addr_b];
    end

    // Observe at negedge: values seen here are what the next posedge samples
    always @(negedge clk) begin
        if (ram_cs) begin
            if (n_issue - n_xfer_old >= 4) credit_viol++;
            n_issue++;
        end
        n_xfer_old = n_xfer;
        if (prev_stall && out_valid && out_data !== prev_data) stall_viol++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            n_xfer++;
        end
        if (done) n_done++;
        if (ram_cs_b) addr_q_b.push_back(ram_addr_b);
        if (out_valid_b && out_ready_b) got_q_b.push_back(out_data_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_issue = 0; n_xfer = 0; n_xfer_old = 0; n_done = 0;
        credit_viol = 0; stall_viol = 0; prev_stall = 1'b0; prev_data = '0;
        got_q.delete(); got_q_b.delete(); addr_q_b.delete();
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: done=%b after %0d clks, required 1", tag, done, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; start_b = 1'b0; row = '0; row_b = '0;
        out_ready = 1'b0; out_ready_b = 1'b0;
        tick(); tick();
        checks += 7;
        if (ram_cs !== 1'b0)     begin failures++; $display("FAIL rst_cs: got %b want 0", ram_cs); end
        if (ram_rw !== 1'b0)     begin failures++; $display("FAIL rst_rw: got %b want 0", ram_rw); end
        if (ram_addr !== 10'h0)  begin failures++; $display("FAIL rst_addr: got %h want 000", ram_addr); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (out_data !== 8'h00)  begin failures++; $display("FAIL rst_data: got %h want 00", out_data); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin failures++; $display("FAIL rst_done: got %b want 0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        clr_mon();
        out_ready = 1'b1; row = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks += 4;
        if (busy !== 1'b1)       begin failures++; $display("FAIL s_busy: got %b want 1", busy); end
        if (ram_cs !== 1'b1)     begin failures++; $display("FAIL s_cs0: got %b want 1", ram_cs); end
        if (ram_addr !== 10'h0)  begin failures++; $display("FAIL s_addr0: got %h want 000", ram_addr); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL s_valid_e0: got %b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL s_valid_e1: got %b want 0", out_valid); end
        tick();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                failures++;
                $display("FAIL s_byte%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(i));
            end
            tick();
        end
        checks += 2;
        if (done !== 1'b1)  begin failures++; $display("FAIL s_done: got %b want 1", done); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL s_busy_end: got %b want 0", busy); end
        tick();
        checks++;
        if (done !== 1'b0)  begin failures++; $display("FAIL s_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int k = 1;
        clr_mon();
        row = 5'd3; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (done !== 1'b1 && k < 400) begin
            out_ready = pat[k % 4];
            tick();
            k++;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL bp_timeout: done=%b want 1", done); end
        out_ready = 1'b1;
        tick();
        checks += 4;
        if (got_q.size() != 32) begin failures++; $display("FAIL bp_count: got %0d want 32", got_q.size()); end
        for (int i = 0; i < 32; i++) begin
            logic [7:0] act = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++;
            if (act !== 8'(8'h60 + i)) begin failures++; $display("FAIL bp_byte%0d: got %h want %h", i, act, 8'(8'h60 + i)); end
        end
        if (credit_viol != 0) begin failures++; $display("FAIL bp_credit: got %0d violations want 0", credit_viol); end
        if (stall_viol != 0)  begin failures++; $display("FAIL bp_stable: got %0d violations want 0", stall_viol); end
        if (n_done != 1)      begin failures++; $display("FAIL bp_ndone: got %0d want 1", n_done); end
    endtask

    task automatic test_wrap();
        int n = 0;
        clr_mon();
        out_ready_b = 1'b1; row_b = 5'd0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if (ram_addr_b !== 10'h3F0) begin failures++; $display("FAIL w_addr0: got %h want 3f0", ram_addr_b); end
        while (done_b !== 1'b1 && n < 100) begin tick(); n++; end
        checks += 4;
        if (done_b !== 1'b1) begin failures++; $display("FAIL w_timeout: done=%b want 1", done_b); end
        tick();
        if (busy_b !== 1'b0)        begin failures++; $display("FAIL w_busy: got %b want 0", busy_b); end
        if (ram_rw_b !== 1'b0)      begin failures++; $display("FAIL w_rw: got %b want 0", ram_rw_b); end
        if (addr_q_b.size() != 32 || got_q_b.size() != 32) begin
            failures++;
            $display("FAIL w_count: got addr=%0d data=%0d want 32/32", addr_q_b.size(), got_q_b.size());
        end
        for (int i = 0; i < 32; i++) begin
            logic [9:0] ea = 10'h3F0 + 10'(i);
            logic [9:0] aa = (i < addr_q_b.size()) ? addr_q_b[i] : 10'hxxx;
            logic [7:0] ad = (i < got_q_b.size()) ? got_q_b[i] : 8'hxx;
            checks++;
            if (aa !== ea || ad !== ea[7:0]) begin
                failures++;
                $display("FAIL w_item%0d: got addr=%h data=%h want %h/%h", i, aa, ad, ea, ea[7:0]);
            end
        end
    endtask

    task automatic test_start_busy();
        clr_mon();
        out_ready = 1'b1; row = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++;
        if (ram_addr !== 10'h029) begin failures++; $display("FAIL sb_addr9: got %h want 029", ram_addr); end
        start = 1'b1; row = 5'd5;
        tick();
        start = 1'b0;
        checks++;
        if (ram_addr !== 10'h02A) begin failures++; $display("FAIL sb_addr10: got %h want 02a", ram_addr); end
        wait_done(100, "sb1");
        checks += 2;
        if (got_q.size() != 32) begin failures++; $display("FAIL sb_count: got %0d want 32", got_q.size()); end
        if (n_done != 0)        begin failures++; $display("FAIL sb_early_done: got %0d want 0", n_done); end
        for (int i = 0; i < 32; i++) begin
            logic [7:0] act = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++;
            if (act !== 8'(8'h20 + i)) begin failures++; $display("FAIL sb_byte%0d: got %h want %h", i, act, 8'(8'h20 + i)); end
        end
        // New start issued in the done cycle itself
        clr_mon();
        start = 1'b1; row = 5'd2;
        tick();
        start = 1'b0;
        checks += 3;
        if (busy !== 1'b1)       begin failures++; $display("FAIL sb2_busy: got %b want 1", busy); end
        if (ram_addr !== 10'h040) begin failures++; $display("FAIL sb2_addr: got %h want 040", ram_addr); end
        if (done !== 1'b0)       begin failures++; $display("FAIL sb2_done: got %b want 0", done); end
        tick();
        checks++;
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL sb2_valid_e1: got %b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h40) begin
            failures++; $display("FAIL sb2_first: got %b/%h want 1/40", out_valid, out_data);
        end
        wait_done(100, "sb2");
        tick();
        checks += 2;
        // Counts the first row's done (seen after the monitor reset) plus this row's
        if (n_done != 2)        begin failures++; $display("FAIL sb2_ndone: got %0d want 2", n_done); end
        if (got_q.size() != 32 || got_q[got_q.size() - 1] !== 8'h5F) begin
            failures++; $display("FAIL sb2_stream: got size=%0d want 32 ending 5f", got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clr_mon();
        out_ready = 1'b0; row = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h80) begin
            failures++; $display("FAIL rm_pre: got %b/%h want 1/80", out_valid, out_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b want 0", out_valid); end
        if (ram_cs !== 1'b0)    begin failures++; $display("FAIL rm_cs: got %b want 0", ram_cs); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL rm_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin failures++; $display("FAIL rm_done: got %b want 0", done); end
        tick(); tick();
        checks += 2;
        if (n_done != 0)        begin failures++; $display("FAIL rm_nodone: got %0d want 0", n_done); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_discard: got %b want 0", out_valid); end
        clr_mon();
        out_ready = 1'b1; row = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, "rm");
        tick();
        checks += 2;
        if (got_q.size() != 32) begin failures++; $display("FAIL rm_count: got %0d want 32", got_q.size()); end
        if (n_done != 1)        begin failures++; $display("FAIL rm_ndone: got %0d want 1", n_done); end
        for (int i = 0; i < 32; i++) begin
            logic [7:0] act = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++;
            if (act !== 8'(8'hE0 + i)) begin failures++; $display("FAIL rm_byte%0d: got %h want %h", i, act, 8'(8'hE0 + i)); end
        end
    endtask

    task automatic test_full_stall();
        clr_mon();
        out_ready = 1'b0; row = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks += 4;
        if (n_issue != 4)       begin failures++; $display("FAIL fs_issues: got %0d want 4", n_issue); end
        if (ram_cs !== 1'b0)    begin failures++; $display("FAIL fs_cs: got %b want 0", ram_cs); end
        if (out_valid !== 1'b1 || out_data !== 8'h40) begin
            failures++; $display("FAIL fs_head: got %b/%h want 1/40", out_valid, out_data);
        end
        if (busy !== 1'b1)      begin failures++; $display("FAIL fs_busy: got %b want 1", busy); end
        out_ready = 1'b1;
        wait_done(100, "fs");
        tick();
        checks += 3;
        if (got_q.size() != 32) begin failures++; $display("FAIL fs_count: got %0d want 32", got_q.size()); end
        if (credit_viol != 0)   begin failures++; $display("FAIL fs_credit: got %0d want 0", credit_viol); end
        if (stall_viol != 0)    begin failures++; $display("FAIL fs_stable: got %0d want 0", stall_viol); end
        for (int i = 0; i < 32; i++) begin
            logic [7:0] act = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++;
            if (act !== 8'(8'h40 + i)) begin failures++; $display("FAIL fs_byte%0d: got %h want %h", i, act, 8'(8'h40 + i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        clr_mon();
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        test_full_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
